// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of the shared main memory.
// Port 0 is the I-cache, port 1 the D-cache. A grant with lock set keeps the
// granted port as owner for the rest of a burst. A MEM_LAT-deep tag pipe
// routes each read's return to the port that issued it.
module mem_arbiter #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        wr0,
  input  logic        wr1,
  input  logic        lock0,
  input  logic        lock1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [15:0] rdata,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_wr,
  input  logic [15:0] mem_data_rd,
  input  logic        mem_stall
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   prio, prio_nxt;

  logic        sel;
  logic        active;
  logic        sel_wr;
  logic        sel_lock;
  logic [15:0] sel_addr;
  logic [15:0] sel_wdata;
  logic        gnt_any;

  logic [MEM_LAT-1:0] tag_v;
  logic [MEM_LAT-1:0] tag_id;

  // Pick the port presented to memory; an owner excludes the other port.
  // Outputs are forced idle while reset is asserted.
  always_comb begin
    sel    = 1'b0;
    active = 1'b0;
    case (state)
      IDLE: begin
        sel    = (req0 && req1) ? prio : req1;
        active = req0 | req1;
      end
      OWN0: begin
        sel    = 1'b0;
        active = req0;
      end
      OWN1: begin
        sel    = 1'b1;
        active = req1;
      end
      default: begin
        sel    = 1'b0;
        active = 1'b0;
      end
    endcase
    if (!rst) active = 1'b0;
  end

  assign sel_wr    = sel ? wr1    : wr0;
  assign sel_lock  = sel ? lock1  : lock0;
  assign sel_addr  = sel ? addr1  : addr0;
  assign sel_wdata = sel ? wdata1 : wdata0;

  assign gnt_any     = active & ~mem_stall;
  assign gnt0        = gnt_any & ~sel;
  assign gnt1        = gnt_any & sel;
  assign mem_rd      = active & ~sel_wr;
  assign mem_wr      = active & sel_wr;
  assign mem_addr    = active ? sel_addr  : '0;
  assign mem_data_wr = active ? sel_wdata : '0;

  assign rdata   = mem_data_rd;
  assign rvalid0 = tag_v[MEM_LAT-1] & ~tag_id[MEM_LAT-1];
  assign rvalid1 = tag_v[MEM_LAT-1] &  tag_id[MEM_LAT-1];

  // Next ownership state and round-robin priority.
  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    if (gnt_any) begin
      prio_nxt  = ~sel;
      state_nxt = sel_lock ? (sel ? OWN1 : OWN0) : IDLE;
    end else if (state == OWN0 && !req0 && !lock0) begin
      state_nxt = IDLE;
    end else if (state == OWN1 && !req1 && !lock1) begin
      state_nxt = IDLE;
    end
  end

  // State and priority registers; D-cache has priority out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      prio  <= 1'b1;
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
    end
  end

  // Read-return tag pipe; shifts every cycle independent of mem_stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v[0]  <= gnt_any & ~sel_wr;
      tag_id[0] <= sel;
      for (int unsigned i = 1; i < MEM_LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by
// randomized cache-like traffic, all checked against a transaction-level model.
module tb_mem_arbiter;

  localparam int MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        wr0 = 1'b0, wr1 = 1'b0;
  logic        lock0 = 1'b0, lock1 = 1'b0;
  logic [15:0] addr0 = '0, addr1 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [15:0] rdata;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_addr, mem_data_wr;
  logic [15:0] mem_data_rd = '0;
  logic        mem_stall = 1'b0;

  mem_arbiter #(.MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_data_wr(mem_data_wr),
    .mem_data_rd(mem_data_rd), .mem_stall(mem_stall)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Transaction-level model: owner (-1 = nobody), priority, outstanding reads.
  typedef struct {
    int          due;
    bit          id;
    logic [15:0] addr;
  } ret_t;

  ret_t q[$];
  int   owner = -1;
  bit   prio = 1'b1;
  int   cyc = 0;
  bit   auto_mode = 1'b0;

  logic exp_g0, exp_g1;
  logic obs_g0, obs_g1, obs_rv0, obs_rv1, obs_wr;
  logic [15:0] obs_rdata;

  // Random cache agents
  bit          a_req[2], a_wr[2], a_lock[2], a_gap[2];
  logic [15:0] a_addr[2], a_data[2];
  int          a_beats[2];

  function automatic logic [15:0] mem_value(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic drive_agents();
    for (int i = 0; i < 2; i++) begin
      bit g;
      g = (i == 0) ? exp_g0 : exp_g1;
      if (a_gap[i]) begin
        a_gap[i]  = 1'b0;
        a_req[i]  = 1'b1;
        a_lock[i] = (a_beats[i] > 1);
      end else if (g) begin
        a_beats[i]--;
        if (a_beats[i] > 0) begin
          a_addr[i] = a_addr[i] + 16'd2;
          a_data[i] = 16'($urandom);
          if ($urandom_range(3) == 0) begin
            a_req[i]  = 1'b0;
            a_lock[i] = 1'b1;
            a_gap[i]  = 1'b1;
          end else begin
            a_lock[i] = (a_beats[i] > 1);
          end
        end else begin
          a_req[i]  = 1'b0;
          a_lock[i] = 1'b0;
        end
      end else if (!a_req[i] && a_beats[i] == 0 && $urandom_range(2) == 0) begin
        a_beats[i] = $urandom_range(1, 4);
        a_wr[i]    = bit'($urandom_range(1));
        a_addr[i]  = 16'($urandom);
        if ($urandom_range(7) != 0) a_addr[i][0] = 1'b0;
        a_data[i]  = 16'($urandom);
        a_lock[i]  = (a_beats[i] > 1);
        a_req[i]   = 1'b1;
      end
    end
    req0 = a_req[0]; wr0 = a_wr[0]; lock0 = a_lock[0]; addr0 = a_addr[0]; wdata0 = a_data[0];
    req1 = a_req[1]; wr1 = a_wr[1]; lock1 = a_lock[1]; addr1 = a_addr[1]; wdata1 = a_data[1];
    mem_stall = ($urandom_range(3) == 0);
  endtask

  task automatic clear_agents();
    for (int i = 0; i < 2; i++) begin
      a_req[i] = 0; a_wr[i] = 0; a_lock[i] = 0; a_gap[i] = 0;
      a_addr[i] = '0; a_data[i] = '0; a_beats[i] = 0;
    end
  endtask

  // One clock cycle: predict and check at negedge, advance model at posedge,
  // then drive next inputs 1 time unit after the edge.
  task automatic step();
    int          s;
    bit          c0, c1, w, lk, rv0, rv1;
    logic [15:0] a, d, rvd;
    ret_t        e;
    @(negedge clk);
    if (!rst) begin
      q.delete();
      owner = -1;
      prio  = 1'b1;
    end
    s  = -1;
    c0 = req0 && (owner != 1);
    c1 = req1 && (owner != 0);
    if (rst) begin
      if (c0 && c1)  s = prio ? 1 : 0;
      else if (c1)   s = 1;
      else if (c0)   s = 0;
    end
    w = 0; lk = 0; a = '0; d = '0;
    if (s >= 0) begin
      w  = (s == 1) ? wr1    : wr0;
      lk = (s == 1) ? lock1  : lock0;
      a  = (s == 1) ? addr1  : addr0;
      d  = (s == 1) ? wdata1 : wdata0;
    end
    exp_g0 = (s == 0) && !mem_stall;
    exp_g1 = (s == 1) && !mem_stall;
    rv0 = 0; rv1 = 0; rvd = '0;
    foreach (q[k]) if (q[k].due == cyc) begin
      if (q[k].id) rv1 = 1; else rv0 = 1;
      rvd = mem_value(q[k].addr);
    end
    chk("gnt0", 16'(gnt0), 16'(exp_g0));
    chk("gnt1", 16'(gnt1), 16'(exp_g1));
    chk("mem_rd", 16'(mem_rd), 16'((s >= 0) && !w));
    chk("mem_wr", 16'(mem_wr), 16'((s >= 0) && w));
    chk("mem_addr", mem_addr, a);
    chk("mem_data_wr", mem_data_wr, w ? d : ((s >= 0) ? d : 16'h0000));
    chk("rvalid0", 16'(rvalid0), 16'(rv0));
    chk("rvalid1", 16'(rvalid1), 16'(rv1));
    chk("rdata_follow", rdata, mem_data_rd);
    if (rv0 || rv1) chk("rdata_value", rdata, rvd);
    obs_g0 = gnt0; obs_g1 = gnt1; obs_rv0 = rvalid0; obs_rv1 = rvalid1;
    obs_wr = mem_wr; obs_rdata = rdata;
    @(posedge clk);
    if (rst) begin
      if (exp_g0 || exp_g1) begin
        prio  = (s == 0);
        owner = lk ? s : -1;
        if (!w) begin
          e.due = cyc + MEM_LAT; e.id = (s == 1); e.addr = a;
          q.push_back(e);
        end
      end else if (owner == 0 && !req0 && !lock0) begin
        owner = -1;
      end else if (owner == 1 && !req1 && !lock1) begin
        owner = -1;
      end
    end else begin
      q.delete();
      owner = -1;
      prio  = 1'b1;
    end
    while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
    cyc++;
    #1;
    mem_data_rd = 16'($urandom);
    foreach (q[k]) if (q[k].due == cyc) mem_data_rd = mem_value(q[k].addr);
    if (auto_mode) drive_agents();
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; wr0 = 0; wr1 = 0; lock0 = 0; lock1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; mem_stall = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    clear_agents();
    idle_inputs();
    @(posedge clk);
    #1;

    // Reset state (outputs checked by step while rst is low)
    do_reset();

    // 1: single read on port 0
    req0 = 1; wr0 = 0; addr0 = 16'h0100;
    step();
    chk("t1_gnt0", 16'(obs_g0), 16'd1);
    req0 = 0;
    step();
    step();
    chk("t1_rvalid0", 16'(obs_rv0), 16'd1);
    chk("t1_rdata", obs_rdata, mem_value(16'h0100));

    // 2: both requesting, no lock -> alternating starting with port 1
    do_reset();
    req0 = 1; addr0 = 16'h0200; req1 = 1; addr1 = 16'h0300;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("t2_gnt1", 16'(obs_g1), 16'((k % 2) == 0));
      chk("t2_gnt0", 16'(obs_g0), 16'((k % 2) == 1));
    end
    idle_inputs();
    step();

    // 3: D-cache locked burst while I-cache waits
    do_reset();
    req0 = 1; addr0 = 16'h0400;
    for (int k = 0; k < 4; k++) begin
      req1 = 1; wr1 = 0; addr1 = 16'h0A00 + 16'(2 * k); lock1 = (k < 3);
      step();
      chk("t3_burst_gnt1", 16'(obs_g1), 16'd1);
      chk("t3_burst_gnt0", 16'(obs_g0), 16'd0);
    end
    req1 = 0; lock1 = 0;
    step();
    chk("t3_after_gnt0", 16'(obs_g0), 16'd1);
    idle_inputs();
    step();

    // 4: stalled write on port 1
    do_reset();
    req1 = 1; wr1 = 1; addr1 = 16'h1234; wdata1 = 16'hBEEF;
    for (int k = 0; k < 4; k++) begin
      mem_stall = (k < 3);
      step();
      chk("t4_mem_wr", 16'(obs_wr), 16'd1);
      chk("t4_gnt1", 16'(obs_g1), 16'(k == 3));
    end
    idle_inputs();
    for (int k = 0; k < MEM_LAT + 2; k++) begin
      step();
      chk("t4_no_rvalid", 16'({obs_rv1, obs_rv0}), 16'd0);
    end

    // 5: reset pulse right after a read grant
    do_reset();
    req0 = 1; wr0 = 0; addr0 = 16'h0500;
    step();
    chk("t5_gnt0", 16'(obs_g0), 16'd1);
    req0 = 0;
    rst = 0;
    step();
    rst = 1;
    step();
    chk("t5_no_rvalid", 16'({obs_rv1, obs_rv0}), 16'd0);
    step();

    // 6: back-to-back reads from different ports
    do_reset();
    req0 = 1; wr0 = 0; addr0 = 16'h0600;
    step();
    chk("t6_gnt0", 16'(obs_g0), 16'd1);
    req0 = 0; req1 = 1; wr1 = 0; addr1 = 16'h0700;
    step();
    chk("t6_gnt1", 16'(obs_g1), 16'd1);
    req1 = 0;
    step();
    chk("t6_rvalid0", 16'(obs_rv0), 16'd1);
    chk("t6_rdata0", obs_rdata, mem_value(16'h0600));
    step();
    chk("t6_rvalid1", 16'(obs_rv1), 16'd1);
    chk("t6_rdata1", obs_rdata, mem_value(16'h0700));

    // Randomized traffic with an occasional mid-stream reset
    do_reset();
    clear_agents();
    auto_mode = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        rst = 0;
        clear_agents();
        idle_inputs();
      end
      if (n == 1502) rst = 1;
      step();
    end
    auto_mode = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
